// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - command/response controller for a single-port RAM with registered read
// Optional feature macro: RAM_PORT_CTRL_CLEAR_EN (zero-fill the whole RAM after reset)
module ram_port_ctrl #(
  parameter int Data_width = 32,
  parameter int Addr_width = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [Addr_width-1:0] cmd_addr,
  input  logic [Data_width-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Data_width-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  ram_we,
  output logic [Addr_width-1:0] ram_address,
  output logic [Data_width-1:0] ram_d,
  input  logic [Data_width-1:0] ram_q
);

  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;
`ifdef RAM_PORT_CTRL_CLEAR_EN
  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_RESET   = ST_CLEAR;
  localparam logic [Addr_width-1:0] CNT_ONE = {{(Addr_width-1){1'b0}}, 1'b1};
`else
  localparam logic [1:0] ST_RESET   = ST_IDLE;
`endif

  logic [1:0]            state_q, state_d;
  logic [Addr_width-1:0] addr_q, addr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [Data_width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  accept;
`ifdef RAM_PORT_CTRL_CLEAR_EN
  logic [Addr_width-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Reset gates cmd_ready directly so nothing is accepted while rst_n is low.
  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != ST_IDLE);

  // Next-state logic: writes complete in IDLE, reads walk CAPTURE -> HOLD -> IDLE.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_PORT_CTRL_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && !cmd_we) begin
          addr_d  = cmd_addr;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // RAM sampled the address on the accept edge; its output is valid now.
        rsp_rdata_d = ram_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
`ifdef RAM_PORT_CTRL_CLEAR_EN
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == {Addr_width{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port drive: command fields pass straight through on an accept, the read
  // address is held otherwise, and the clear sweep owns the port while active.
  always_comb begin
    ram_we      = 1'b0;
    ram_address = addr_q;
    ram_d       = cmd_wdata;
    if (accept) begin
      ram_we      = cmd_we;
      ram_address = cmd_addr;
    end
`ifdef RAM_PORT_CTRL_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      ram_we      = rst_n;
      ram_address = clr_cnt_q;
      ram_d       = '0;
    end
`endif
  end

  // State registers; asynchronous reset discards any read or clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef RAM_PORT_CTRL_CLEAR_EN
  // Clear sweep address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb/tb_ram_port_ctrl.sv - randomized self-checking bench for ram_port_ctrl
// Optional feature macro: RAM_PORT_CTRL_CLEAR_EN (selects the clear-after-reset checks)
module tb_ram_port_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_q;

  int n_checks = 0;
  int n_pass   = 0;

  // downstream RAM with registered read port
  logic [DW-1:0] ram_mem [DEPTH];

  // reference model: contents the RAM must hold, and which words are defined
  logic [DW-1:0] exp_mem [DEPTH];
  bit            known   [DEPTH];

  ram_port_ctrl #(.Data_width(DW), .Addr_width(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .ram_we     (ram_we),
    .ram_address(ram_address),
    .ram_d      (ram_d),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address] <= ram_d;
    ram_q <= ram_mem[ram_address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
      known[i]   = 1'b1;
    end
  endtask

  // after reset release, count busy cycles and check the ascending zero sweep
  task automatic wait_clear();
    int n = 0;
    while (busy && n < 1000) begin
      check("clr_we", ram_we, 1);
      check("clr_addr", ram_address, n % DEPTH);
      check("clr_d", ram_d, 0);
      n++;
      step();
    end
    check("clr_busy_cycles", n, DEPTH);
    check("clr_done_ready", cmd_ready, 1);
    model_clear();
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_ram_we", ram_we, 0);
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    #1;
    check("wr_cmd_ready", cmd_ready, 1);
    check("wr_ram_we", ram_we, 1);
    check("wr_ram_addr", ram_address, a);
    check("wr_ram_d", ram_d, d);
    step();
    exp_mem[a] = d;
    known[a]   = 1'b1;
  endtask

  // junk command offered while the controller must refuse commands
  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_we    = 1'b1;
    cmd_addr  = AW'($urandom_range(0, DEPTH - 1));
    cmd_wdata = $urandom;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    logic [DW-1:0] first;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = a;
    #1;
    check("rd_cmd_ready", cmd_ready, 1);
    check("rd_ram_we", ram_we, 0);
    check("rd_ram_addr", ram_address, a);
    step();
    junk_cmd();
    rsp_ready = 1'($urandom_range(0, 1));
    #1;
    check("cap_busy", busy, 1);
    check("cap_cmd_ready", cmd_ready, 0);
    check("cap_ram_we", ram_we, 0);
    check("cap_ram_addr", ram_address, a);
    check("cap_rsp_valid", rsp_valid, 0);
    step();
    junk_cmd();
    rsp_ready = (hold == 0);
    #1;
    check("hold_rsp_valid", rsp_valid, 1);
    check("hold_cmd_ready", cmd_ready, 0);
    if (known[a]) check("hold_rsp_rdata", rsp_rdata, exp_mem[a]);
    first = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      step();
      junk_cmd();
      if (i == hold - 1) rsp_ready = 1'b1;
      #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_rdata", rsp_rdata, first);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_ram_we", ram_we, 0);
    end
    step();
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_busy", busy, 0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
`ifdef RAM_PORT_CTRL_CLEAR_EN
    wait_clear();
`else
    check("rst_first_cmd_ready", cmd_ready, 1);
    check("rst_first_busy", busy, 0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = $urandom;
      exp_mem[i] = '0;
      known[i]   = 1'b0;
    end

    repeat (3) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    release_reset();

`ifdef RAM_PORT_CTRL_CLEAR_EN
    do_read(7'd127, 0);
`endif

    // directed: write then read back with consumer ready
    do_write(7'd5, 32'hDEAD_BEEF);
    cmd_valid = 1'b0;
    do_read(7'd5, 0);

    // directed: stalled response for 10 cycles
    do_write(7'd9, 32'h1234_5678);
    cmd_valid = 1'b0;
    do_read(7'd9, 10);

    // full-depth back-to-back writes, then read every word back
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'(i * 3));
    idle_cycle();
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), $urandom_range(0, 2));

    // random mix of writes, reads and idle cycles
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 4))
        0, 1:    do_write(AW'($urandom_range(0, DEPTH - 1)), $urandom);
        2, 3:    do_read(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 4));
        default: idle_cycle();
      endcase
    end
    idle_cycle();

    // reset while a read is in CAPTURE: response must be discarded
    do_write(7'd3, 32'hA5A5_A5A5);
    cmd_valid = 1'b0;
    do_read(7'd3, 0);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 7'd3;
    step();
    cmd_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrd_rsp_valid", rsp_valid, 0);
    check("midrd_rsp_rdata", rsp_rdata, 0);
    check("midrd_cmd_ready", cmd_ready, 0);
    check("midrd_ram_we", ram_we, 0);
    step();
    release_reset();
    for (int i = 0; i < 4; i++) begin
      check("post_rst_rsp_valid", rsp_valid, 0);
      step();
    end
    do_read(7'd3, 1);
    do_write(7'd127, 32'hCAFE_F00D);
    cmd_valid = 1'b0;
    do_read(7'd127, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
